// File: rtl/fixed_point_pkg.sv
// Q16.16 signed fixed-point format shared by the vector_math datapath.
package fixed_point;

    localparam int FP_W    = 32;
    localparam int FP_FRAC = 16;

    typedef logic signed [FP_W-1:0] fixed_point_t;

endpackage

// File: rtl/vector_pkg.sv
// Three-axis vector of fixed-point values used across vector_math.
package vector;

    typedef struct packed {
        fixed_point::fixed_point_t x;
        fixed_point::fixed_point_t y;
        fixed_point::fixed_point_t z;
    } vector_t;

endpackage

// File: rtl/fixed_point_add.sv
// Wrapping fixed-point adder with signed-overflow detect.
module fixed_point_add
    import fixed_point::*;
(
    input  fixed_point_t a,
    input  fixed_point_t b,
    output fixed_point_t sum,
    output logic         overflow
);

    assign sum = a + b;

    // Overflow when both operands share a sign the result does not.
    assign overflow = (a[FP_W-1] == b[FP_W-1]) &&
                      (sum[FP_W-1] != a[FP_W-1]);

endmodule

// File: rtl/vector_add.sv
// Per-axis vector add; overflow is the OR of the three axes.
module vector_add
    import vector::*;
(
    input  vector_t a,
    input  vector_t b,
    output vector_t sum,
    output logic    overflow
);

    logic ovf_x;
    logic ovf_y;
    logic ovf_z;

    fixed_point_add u_add_x (
        .a        (a.x),
        .b        (b.x),
        .sum      (sum.x),
        .overflow (ovf_x)
    );

    fixed_point_add u_add_y (
        .a        (a.y),
        .b        (b.y),
        .sum      (sum.y),
        .overflow (ovf_y)
    );

    fixed_point_add u_add_z (
        .a        (a.z),
        .b        (b.z),
        .sum      (sum.z),
        .overflow (ovf_z)
    );

    assign overflow = ovf_x | ovf_y | ovf_z;

endmodule

// File: rtl/ray_step_accumulator.sv
// Emits origin + k*step for k = 0..num_steps-1, one point per cycle.
module ray_step_accumulator
    import vector::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_valid,
    output logic             start_ready,
    input  vector_t          origin,
    input  vector_t          step,
    input  logic             step_overflow,
    input  logic [CNT_W-1:0] num_steps,
    output logic             out_valid,
    input  logic             out_ready,
    output vector_t          out_point,
    output logic [CNT_W-1:0] out_index,
    output logic             out_last,
    output logic             out_overflow,
    output logic             busy
);

    typedef enum logic {
        IDLE,
        EMIT
    } state_t;

    state_t           state;
    state_t           state_nxt;
    vector_t          step_q;
    vector_t          add_sum;
    logic [CNT_W-1:0] num_steps_q;
    logic             add_overflow;
    logic             start_fire;
    logic             out_fire;

    vector_add u_vector_add (
        .a        (out_point),
        .b        (step_q),
        .sum      (add_sum),
        .overflow (add_overflow)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        start_ready = 1'b0;
        out_valid   = 1'b0;
        out_last    = 1'b0;
        busy        = 1'b0;
        start_fire  = 1'b0;
        out_fire    = 1'b0;
        unique case (state)
            IDLE: begin
                start_ready = 1'b1;
                start_fire  = start_valid;
                // A zero-length job is latched but never leaves IDLE.
                if (start_valid && (num_steps != '0)) begin
                    state_nxt = EMIT;
                end
            end
            EMIT: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                out_last  = (out_index == num_steps_q - CNT_W'(1));
                out_fire  = out_ready;
                if (out_ready && out_last) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step_q       <= '0;
            num_steps_q  <= '0;
            out_point    <= '0;
            out_index    <= '0;
            out_overflow <= 1'b0;
        end else if (start_fire) begin
            step_q       <= step;
            num_steps_q  <= num_steps;
            out_point    <= origin;
            out_index    <= '0;
            out_overflow <= step_overflow;
        end else if (out_fire && !out_last) begin
            out_point    <= add_sum;
            out_index    <= out_index + CNT_W'(1);
            out_overflow <= out_overflow | add_overflow;
        end
    end

endmodule
